// File: rtl/lcd_button_in.sv
// Avalon-MM push-button/switch input PIO: pin synchronizer, edge capture and maskable level irq.
// Optional per-bit debounce filter is built when LCD_BUTTON_DEBOUNCE_EN is defined.
module lcd_button_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_p0, sync_p1, f, prev_p2;
  logic [WIDTH-1:0] mask, cap, edge_det, clr, cap_next, mask_next;
  logic [1:0]       primed;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_bits;

  assign wr_en       = chipselect & ~write_n;
  assign unused_bits = &{1'b0, writedata, (DEBOUNCE_CYCLES > 1)};

  // Stage p0/p1: two-flop synchronizer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
    end
  end

`ifdef LCD_BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [WIDTH-1:0] stable;
  logic [CW-1:0]    db_cnt [WIDTH];

  // A bit only changes after it has disagreed with stable for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_p1[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= sync_p1[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign f = stable;
`else
  assign f = sync_p1;
`endif

  // Edges are suppressed until the synchronizer has flushed its reset zeros
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = f & ~prev_p2;
      1:       edge_det = ~f & prev_p2;
      default: edge_det = f ^ prev_p2;
    endcase
    if (primed != 2'd3) edge_det = '0;
  end

  always_comb begin
    clr       = '0;
    mask_next = mask;
    if (wr_en && address == 2'd3) clr = writedata[WIDTH-1:0];
    if (wr_en && address == 2'd2) mask_next = writedata[WIDTH-1:0];
    cap_next = (cap & ~clr) | edge_det;
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = f;
      2'd2:    rd_next[WIDTH-1:0] = mask;
      2'd3:    rd_next[WIDTH-1:0] = cap;
      default: rd_next = '0;
    endcase
  end

  // Stage p2: edge compare, capture, mask, registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_p2  <= '0;
      primed   <= '0;
      cap      <= '0;
      mask     <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      prev_p2  <= f;
      if (primed != 2'd3) primed <= primed + 1'b1;
      cap      <= cap_next;
      mask     <= mask_next;
      irq      <= |(cap_next & mask_next);
      readdata <= rd_next;
    end
  end

endmodule
